// File: rtl/coin_change_dispenser_if.sv
// Purpose: groups the change-load request and the dispenser status/solenoid
//          signals of coin_change_dispenser into one bundle.
// Signals:
//   change_in[7:0], change_valid   change amount and its load strobe (to dispenser)
//   eject_20, eject_10, eject_5    solenoid drives, at most one high (from dispenser)
//   busy, done                     job in progress / end-of-job strobe
//   coins_out[7:0], remaining[7:0] coins ejected this job / amount still owed
//   error, dropped                 residue-or-overrange flag / sticky lost-load flag
// Modports: master = the side issuing change (controller or bench),
//           slave  = the dispenser.
interface coin_change_dispenser_if;
  logic [7:0] change_in;
  logic       change_valid;
  logic       eject_20;
  logic       eject_10;
  logic       eject_5;
  logic       busy;
  logic       done;
  logic [7:0] coins_out;
  logic [7:0] remaining;
  logic       error;
  logic       dropped;

  modport master (
    output change_in, change_valid,
    input  eject_20, eject_10, eject_5, busy, done,
    input  coins_out, remaining, error, dropped
  );

  modport slave (
    input  change_in, change_valid,
    output eject_20, eject_10, eject_5, busy, done,
    output coins_out, remaining, error, dropped
  );
endinterface

// File: rtl/coin_change_dispenser.sv
// Purpose: pays out a change amount as 20/10/5 coins, largest first, one timed
//          solenoid pulse per coin followed by a quiet gap, then reports the
//          result with a one-cycle done strobe.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high reset; abandons any job without a done strobe
//   bus    coin_change_dispenser_if.slave: change_in/change_valid in; eject_*,
//          busy, done, coins_out, remaining, error, dropped out (all registered)
module coin_change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned MAX_AMOUNT   = 99
) (
  input  logic                     clk,
  input  logic                     reset,
  coin_change_dispenser_if.slave   bus
);

  localparam int unsigned AMT_W   = 8;
  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAX_AMOUNT);
  localparam logic [AMT_W-1:0] COIN_20 = AMT_W'(20);
  localparam logic [AMT_W-1:0] COIN_10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] COIN_5  = AMT_W'(5);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AMT_W-1:0] denom;
  logic             eject_20_q;
  logic             eject_10_q;
  logic             eject_5_q;
  logic             busy_q;
  logic             done_q;
  logic [AMT_W-1:0] coins_q;
  logic [AMT_W-1:0] remaining_q;
  logic             error_q;
  logic             dropped_q;

  // Job sequencer: all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      denom       <= '0;
      eject_20_q  <= 1'b0;
      eject_10_q  <= 1'b0;
      eject_5_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coins_q     <= '0;
      remaining_q <= '0;
      error_q     <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A load request arriving mid-job is lost; remember that it happened.
      if (state != S_IDLE && bus.change_valid) begin
        dropped_q <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (bus.change_valid && bus.change_in != '0) begin
            coins_q     <= '0;
            dropped_q   <= 1'b0;
            busy_q      <= 1'b1;
            remaining_q <= bus.change_in;
            if (bus.change_in > MAX_AMT) begin
              // Out of range: report the whole amount as residue, eject nothing.
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state   <= S_DONE;
            end else begin
              error_q <= 1'b0;
              state   <= S_SELECT;
            end
          end
        end

        S_SELECT: begin
          cnt <= '0;
          if (remaining_q >= COIN_20) begin
            denom      <= COIN_20;
            eject_20_q <= 1'b1;
            state      <= S_PULSE;
          end else if (remaining_q >= COIN_10) begin
            denom      <= COIN_10;
            eject_10_q <= 1'b1;
            state      <= S_PULSE;
          end else if (remaining_q >= COIN_5) begin
            denom      <= COIN_5;
            eject_5_q  <= 1'b1;
            state      <= S_PULSE;
          end else begin
            // Anything below the smallest coin is undispensable residue.
            error_q <= (remaining_q != '0);
            done_q  <= 1'b1;
            state   <= S_DONE;
          end
        end

        S_PULSE: begin
          if (cnt == PULSE_LAST) begin
            eject_20_q  <= 1'b0;
            eject_10_q  <= 1'b0;
            eject_5_q   <= 1'b0;
            // denom <= remaining_q was guaranteed when the coin was chosen.
            remaining_q <= remaining_q - denom;
            coins_q     <= coins_q + AMT_W'(1);
            cnt         <= '0;
            state       <= S_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_SELECT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Two solenoids firing together would jam the coin path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0({eject_20_q, eject_10_q, eject_5_q}));
    end
  end

  assign bus.eject_20  = eject_20_q;
  assign bus.eject_10  = eject_10_q;
  assign bus.eject_5   = eject_5_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.coins_out = coins_q;
  assign bus.remaining = remaining_q;
  assign bus.error     = error_q;
  assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Purpose: directed self-checking bench for coin_change_dispenser.
//   Each job records the per-cycle eject pattern and compares it against a
//   pattern built from the hand-derived coin list for that amount.
module tb_coin_change_dispenser;
  localparam int unsigned P    = 4;
  localparam int unsigned G    = 2;
  localparam int unsigned MAXA = 99;

  logic clk = 1'b0;
  logic reset;

  coin_change_dispenser_if bus ();

  coin_change_dispenser #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .MAX_AMOUNT   (MAXA)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // 0 = no eject, 20/10/5 = that coin, 99 = more than one solenoid high.
  function automatic int eject_code();
    if ($countones({bus.eject_20, bus.eject_10, bus.eject_5}) > 1) return 99;
    if (bus.eject_20) return 20;
    if (bus.eject_10) return 10;
    if (bus.eject_5)  return 5;
    return 0;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Load an amount, follow the job to its done strobe and check the result.
  task automatic run_job(input string tag, input int amt, input int coins[8],
                         input int ncoins, input bit direct, input int exp_rem,
                         input int exp_err, input int drop_at);
    int got[256];
    int exp_tr[256];
    int n;
    int exp_done;
    int k;
    int busy_ok;
    int bad;
    bit found;

    // Expected pattern: per coin SELECT, P pulse cycles, G gap cycles; then a
    // final SELECT and the DONE cycle. Out-of-range goes straight to DONE.
    n = 0;
    if (!direct) begin
      for (int c = 0; c < ncoins; c++) begin
        exp_tr[n] = 0; n = n + 1;
        for (int p = 0; p < int'(P); p++) begin exp_tr[n] = coins[c]; n = n + 1; end
        for (int g = 0; g < int'(G); g++) begin exp_tr[n] = 0; n = n + 1; end
      end
      exp_tr[n] = 0; n = n + 1;
    end
    exp_done = n;
    exp_tr[exp_done] = 0;

    bus.change_in    = 8'(amt);
    bus.change_valid = 1'b1;
    next_cycle();
    bus.change_valid = 1'b0;
    bus.change_in    = 8'd0;

    k = 0;
    busy_ok = 1;
    got[0] = eject_code();
    if (!bus.busy) busy_ok = 0;
    while (!bus.done && k < 200) begin
      if (k == drop_at) begin
        bus.change_in    = 8'd15;
        bus.change_valid = 1'b1;
      end else begin
        bus.change_in    = 8'd0;
        bus.change_valid = 1'b0;
      end
      next_cycle();
      k = k + 1;
      got[k] = eject_code();
      if (!bus.busy) busy_ok = 0;
    end
    bus.change_valid = 1'b0;
    bus.change_in    = 8'd0;

    check({tag, "_done_at"}, k, exp_done);
    found = 1'b0;
    bad = 0;
    for (int i = 0; i <= exp_done && i <= k && !found; i++) begin
      if (got[i] != exp_tr[i]) begin
        bad = i;
        found = 1'b1;
      end
    end
    check({tag, "_eject_trace_cyc", $sformatf("%0d", bad)}, got[bad], exp_tr[bad]);
    if (ncoins > 0) check({tag, "_first_eject"}, got[1], coins[0]);
    check({tag, "_busy_thru_done"}, busy_ok, 1);
    check({tag, "_coins_out"}, int'(bus.coins_out), ncoins);
    check({tag, "_remaining"}, int'(bus.remaining), exp_rem);
    check({tag, "_error"}, int'(bus.error), exp_err);

    next_cycle();
    check({tag, "_done_1cyc"}, int'(bus.done), 0);
    check({tag, "_busy_after"}, int'(bus.busy), 0);
    check({tag, "_coins_hold"}, int'(bus.coins_out), ncoins);
    check({tag, "_rem_hold"}, int'(bus.remaining), exp_rem);
    check({tag, "_err_hold"}, int'(bus.error), exp_err);
  endtask

  initial begin
    int done_seen;
    int eject_seen;

    reset            = 1'b1;
    bus.change_in    = 8'd0;
    bus.change_valid = 1'b0;
    @(negedge clk);
    next_cycle();
    // Load request coincident with reset must be ignored.
    bus.change_in    = 8'd40;
    bus.change_valid = 1'b1;
    next_cycle();
    bus.change_valid = 1'b0;
    bus.change_in    = 8'd0;
    reset            = 1'b0;

    check("rst_eject",     eject_code(), 0);
    check("rst_busy",      int'(bus.busy), 0);
    check("rst_done",      int'(bus.done), 0);
    check("rst_coins",     int'(bus.coins_out), 0);
    check("rst_remaining", int'(bus.remaining), 0);
    check("rst_error",     int'(bus.error), 0);
    check("rst_dropped",   int'(bus.dropped), 0);
    next_cycle();
    check("rst_no_latch_busy", int'(bus.busy), 0);

    // Zero amount with the strobe is not a job.
    bus.change_valid = 1'b1;
    next_cycle();
    bus.change_valid = 1'b0;
    check("zero_ignored_busy", int'(bus.busy), 0);

    run_job("amt40", 40, '{20, 20, 0, 0, 0, 0, 0, 0}, 2, 1'b0, 0, 0, -1);
    check("amt40_dropped", int'(bus.dropped), 0);
    run_job("amt35", 35, '{20, 10, 5, 0, 0, 0, 0, 0}, 3, 1'b0, 0, 0, -1);
    run_job("amt7", 7, '{5, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0, 2, 1, -1);

    bus.change_valid = 1'b1;
    next_cycle();
    bus.change_valid = 1'b0;
    check("zero_idle_busy", int'(bus.busy), 0);
    check("zero_idle_rem_hold", int'(bus.remaining), 2);

    run_job("amt120", 120, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b1, 120, 1, -1);
    run_job("amt99", 99, '{20, 20, 20, 20, 10, 5, 0, 0}, 6, 1'b0, 4, 1, -1);
    run_job("amt100", 100, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b1, 100, 1, -1);

    run_job("amt30_drop", 30, '{20, 10, 0, 0, 0, 0, 0, 0}, 2, 1'b0, 0, 0, 3);
    check("amt30_dropped_set", int'(bus.dropped), 1);
    run_job("amt5", 5, '{5, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0, 0, 0, -1);
    check("amt5_dropped_clr", int'(bus.dropped), 0);

    // Abandon a job with reset in the second pulse cycle of the first coin.
    bus.change_in    = 8'd60;
    bus.change_valid = 1'b1;
    next_cycle();
    bus.change_valid = 1'b0;
    bus.change_in    = 8'd0;
    next_cycle();
    check("rst60_pulse1", eject_code(), 20);
    next_cycle();
    check("rst60_pulse2", eject_code(), 20);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("rst60_eject", eject_code(), 0);
    check("rst60_busy",  int'(bus.busy), 0);
    check("rst60_done",  int'(bus.done), 0);
    check("rst60_rem",   int'(bus.remaining), 0);
    done_seen  = 0;
    eject_seen = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (bus.done) done_seen = 1;
      if (eject_code() != 0) eject_seen = 1;
    end
    check("rst60_no_done", done_seen, 0);
    check("rst60_no_eject", eject_seen, 0);

    run_job("amt10", 10, '{10, 0, 0, 0, 0, 0, 0, 0}, 1, 1'b0, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
